comparator_serial: RTL and testbench

Multi-cycle signed magnitude/equality comparator for two N-bit words. It scans K bits per cycle, MSB chunk first.
- Inputs are accepted over a valid/ready handshake; results (eq, lt) are returned over a second valid/ready handshake.
- It is the sequential, area-reduced counterpart to the single-cycle combinational comparators. It is used where an N-bit compare does not fit in one cycle or area is tight.

---
 rtl/comparator_pkg.sv | 13 +
 rtl/comparator_chunk.sv | 30 +++
 rtl/comparator_serial.sv | 117 +++++++++++
 tb/tb_comparator_serial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and default sizing for the serial signed comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CMP_N = 32;
    localparam int CMP_K = 4;

endpackage

// File: rtl/comparator_chunk.sv
// K-bit chunk compare; signed mode treats bit K-1 as the two's-complement sign.
// Latency: combinational.
// Backpressure: none.
module comparator_chunk #(
    parameter int K = 4
) (
    input  logic [K-1:0] ca,
    input  logic [K-1:0] cb,
    input  logic         is_signed,
    output logic         ceq,
    output logic         clt
);

    logic [K-1:0] xa;
    logic [K-1:0] xb;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        xa = ca;
        xb = cb;
        if (is_signed) begin
            xa[K-1] = ~ca[K-1];
            xb[K-1] = ~cb[K-1];
        end
    end

    assign ceq = (ca == cb);
    assign clt = (xa < xb);

endmodule

// File: rtl/comparator_serial.sv
// Serial signed eq/lt comparator, K bits per cycle MSB chunk first, valid/ready in and out.
// Latency: N/K cycles; first-mismatch exit when COMPARATOR_SERIAL_EARLY_EXIT_EN is defined.
// Backpressure: one op in flight; i_ready low until the result is taken via o_ready.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int N = CMP_N,
    parameter int K = CMP_K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         eq,
    output logic         lt
);

    localparam int CHUNKS = N / K;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    generate
        if (N % K != 0) begin : g_bad_chunking
            $error("comparator_serial: N must be a multiple of K");
        end
    endgenerate

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          first;
    logic          decided;
    logic          ceq;
    logic          clt;
    logic          scan_end;

    comparator_chunk #(
        .K (K)
    ) u_chunk (
        .ca        (sa[N-1 -: K]),
        .cb        (sb[N-1 -: K]),
        .is_signed (first),
        .ceq       (ceq),
        .clt       (clt)
    );

    assign i_ready = (state == S_IDLE);

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    assign scan_end = (cnt == '0) || !ceq;
`else
    assign scan_end = (cnt == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            first   <= 1'b0;
            decided <= 1'b0;
            o_valid <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        sa      <= a;
                        sb      <= b;
                        cnt     <= CW'(CHUNKS - 1);
                        first   <= 1'b1;
                        decided <= 1'b0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    first <= 1'b0;
                    sa    <= sa << K;
                    sb    <= sb << K;
                    cnt   <= cnt - 1'b1;
                    // Only the most significant differing chunk decides the result.
                    if (!ceq && !decided) begin
                        decided <= 1'b1;
                        eq      <= 1'b0;
                        lt      <= clt;
                    end else if ((cnt == '0) && !decided) begin
                        eq <= 1'b1;
                        lt <= 1'b0;
                    end
                    if (scan_end) begin
                        o_valid <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial (N=32, K=4) with a per-cycle arithmetic reference model.
module tb_comparator_serial;

    localparam int N = 32;
    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         o_valid;
    logic         o_ready;
    logic         eq;
    logic         lt;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic inflight = 1'b0;
    logic mdl_eq = 1'b0;
    logic mdl_lt = 1'b0;
    int   mdl_lat = 0;

    comparator_serial #(
        .N (N),
        .K (K)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .a       (a),
        .b       (b),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .eq      (eq),
        .lt      (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // Reference: plain signed arithmetic; latency is first differing chunk + 1 when exiting early.
    task automatic model(input logic [31:0] va, input logic [31:0] vb,
                         output logic e, output logic l, output int lat);
        bit found;
        e     = (va == vb);
        l     = ($signed(va) < $signed(vb));
        lat   = N / K;
        found = 1'b0;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        for (int i = 0; i < N / K; i++) begin
            if (!found && (va[N-1-i*K -: K] != vb[N-1-i*K -: K])) begin
                found = 1'b1;
                lat   = i + 1;
            end
        end
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && inflight && o_valid) begin
            chk("cmp_eq", {31'd0, eq}, {31'd0, mdl_eq});
            chk("cmp_lt", {31'd0, lt}, {31'd0, mdl_lt});
            chk("cmp_irdy", {31'd0, i_ready}, 32'd0);
        end
    end

    task automatic do_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                         input logic xe, input logic xl, input int lat_e, input int lat_f,
                         input int hold, input bit scramble);
        int   cyc;
        bit   got;
        int   lat_x;
        logic me;
        logic ml;
        int   mlat;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        lat_x = lat_e;
`else
        lat_x = lat_f;
`endif
        model(va, vb, me, ml, mlat);
        chk({nm, "_mdl_eq"}, {31'd0, me}, {31'd0, xe});
        chk({nm, "_mdl_lt"}, {31'd0, ml}, {31'd0, xl});
        chk({nm, "_mdl_lat"}, mlat, lat_x);
        mdl_eq  = me;
        mdl_lt  = ml;
        mdl_lat = mlat;

        @(negedge clk);
        chk({nm, "_irdy_pre"}, {31'd0, i_ready}, 32'd1);
        a       = va;
        b       = vb;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        inflight = 1'b1;
        if (scramble) begin
            a = ~va;
            b = vb ^ 32'h5A5A_5A5A;
        end

        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_valid) got = 1'b1;
        end
        chk({nm, "_latency"}, cyc, lat_x);
        chk({nm, "_eq"}, {31'd0, eq}, {31'd0, xe});
        chk({nm, "_lt"}, {31'd0, lt}, {31'd0, xl});

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_vld"}, {31'd0, o_valid}, 32'd1);
            chk({nm, "_hold_eq"}, {31'd0, eq}, {31'd0, xe});
            chk({nm, "_hold_lt"}, {31'd0, lt}, {31'd0, xl});
            chk({nm, "_hold_irdy"}, {31'd0, i_ready}, 32'd0);
        end

        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready  = 1'b0;
        inflight = 1'b0;
        chk({nm, "_post_vld"}, {31'd0, o_valid}, 32'd0);
        chk({nm, "_post_irdy"}, {31'd0, i_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        a       = '0;
        b       = '0;
        #12;
        chk("rst_vld", {31'd0, o_valid}, 32'd0);
        chk("rst_eq", {31'd0, eq}, 32'd0);
        chk("rst_lt", {31'd0, lt}, 32'd0);
        chk("rst_irdy", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("equal",   32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 8, 8, 0, 1'b0);
        do_op("minneg",  32'h80000000, 32'h00000000, 1'b0, 1'b1, 1, 8, 0, 1'b0);
        do_op("lsb",     32'h12345678, 32'h12345679, 1'b0, 1'b1, 8, 8, 0, 1'b0);
        do_op("negs",    32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 8, 8, 0, 1'b0);
        do_op("stall",   32'h00000010, 32'h00000001, 1'b0, 1'b0, 7, 8, 5, 1'b0);
        do_op("b2b",     32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1, 8, 0, 1'b0);
        do_op("scramble", 32'h00000100, 32'h00000200, 1'b0, 1'b1, 6, 8, 0, 1'b1);

        // Reset lands at cycle 3 of an operation whose decision is already latched.
        @(negedge clk);
        a        = 32'h80000000;
        b        = 32'h00000000;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        inflight = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        inflight = 1'b0;
        #1;
        chk("midrst_vld", {31'd0, o_valid}, 32'd0);
        chk("midrst_eq", {31'd0, eq}, 32'd0);
        chk("midrst_lt", {31'd0, lt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_irdy", {31'd0, i_ready}, 32'd1);
        do_op("after_rst", 32'h00000005, 32'hFFFFFFFD, 1'b0, 1'b0, 1, 8, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
